// File: rtl/fetch_mem_pkg.sv
// ============================================================================
// Module   : fetch_mem_pkg
// Brief    : Shared types, defaults and PC-to-word-index helper for the fetch
//            instruction-memory responder. See fetch_mem_responder for the
//            optional FETCH_MEM_ACCESS_FAULT_EN build macro.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_mem_pkg;

    localparam int C_ADDR_WIDTH = 32;
    localparam int C_INST_WIDTH = 32;
    localparam int C_LATENCY    = 2;
    localparam int C_RESP_DEPTH = 4;

    typedef struct packed {
        logic [C_ADDR_WIDTH-1:0] pc;
        logic [C_INST_WIDTH-1:0] inst;
        logic                    fault;
    } resp_entry_t;

    // Callers truncate the result to their RAM index width.
    function automatic logic [63:0] pc_word_index(input logic [63:0] pc);
        return pc >> 2;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_mem_resp_queue.sv
// ============================================================================
// Module   : fetch_mem_resp_queue
// Brief    : In-order FIFO with wrap-around pointers and a flush that empties
//            it on the next edge. Push while full is allowed with a pop.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_mem_resp_queue
    import fetch_mem_pkg::*;
#(
    parameter int WIDTH = C_ADDR_WIDTH + C_INST_WIDTH,
    parameter int DEPTH = C_RESP_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_pop  = i_pop && !o_empty;
    // When full, the slot being written is the head leaving on this edge.
    assign w_do_push = i_push && (!w_full || w_do_pop);
    assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_mem_responder.sv
// ============================================================================
// Module   : fetch_mem_responder
// Brief    : Instruction-memory responder for fetch: credit-limited fixed
//            latency RAM read pipeline feeding an in-order response queue.
//            Define FETCH_MEM_ACCESS_FAULT_EN to add the resp_fault port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_mem_responder
    import fetch_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int INST_WIDTH = C_INST_WIDTH,
    parameter int DEPTH_LOG  = 10,
    parameter int LATENCY    = C_LATENCY,
    parameter int RESP_DEPTH = C_RESP_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_pc,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [ADDR_WIDTH-1:0] resp_pc,
    output logic [INST_WIDTH-1:0] resp_inst,
`ifdef FETCH_MEM_ACCESS_FAULT_EN
    output logic                  resp_fault,
`endif
    input  logic                  flush,
    input  logic                  load_we,
    input  logic [DEPTH_LOG-1:0]  load_addr,
    input  logic [INST_WIDTH-1:0] load_data
);

    localparam int CW = $clog2(RESP_DEPTH) + 1;
`ifdef FETCH_MEM_ACCESS_FAULT_EN
    localparam int EW = ADDR_WIDTH + INST_WIDTH + 1;
`else
    localparam int EW = ADDR_WIDTH + INST_WIDTH;
`endif

    logic [INST_WIDTH-1:0] r_mem [2**DEPTH_LOG];
    logic [CW-1:0]         r_count;
    logic [DEPTH_LOG-1:0]  w_idx;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_empty;
    logic                  w_req_fault;
    logic                  w_push;
    logic [ADDR_WIDTH-1:0] w_push_pc;
    logic [INST_WIDTH-1:0] w_raw_inst;
    logic [INST_WIDTH-1:0] w_push_inst;
    logic                  w_push_fault;
    logic [EW-1:0]         w_wdata;
    logic [EW-1:0]         w_rdata;

    assign w_idx     = DEPTH_LOG'(pc_word_index(64'(req_pc)));
    assign req_ready = !reset && !flush && (r_count < CW'(RESP_DEPTH));
    assign w_accept  = req_valid && req_ready;
    assign w_pop     = resp_valid && resp_ready;

`ifdef FETCH_MEM_ACCESS_FAULT_EN
    assign w_req_fault = (|req_pc[ADDR_WIDTH-1:DEPTH_LOG+2]) || (|req_pc[1:0]);
`else
    assign w_req_fault = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (load_we) begin
            r_mem[load_addr] <= load_data;
        end
    end

    // Occupancy covers pipeline plus queue, so a pipeline push always finds a slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (flush) begin
            r_count <= '0;
        end else if (w_accept && !w_pop) begin
            r_count <= r_count + 1'b1;
        end else if (!w_accept && w_pop) begin
            r_count <= r_count - 1'b1;
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            // The queue slot itself serves as the synchronous read register.
            always_comb begin
                w_push       = w_accept;
                w_push_pc    = req_pc;
                w_raw_inst   = r_mem[w_idx];
                w_push_fault = w_req_fault;
            end
        end else begin : g_pipe
            // LATENCY-1 registered stages; the queue entry is the final stage.
            localparam int NSTG = LATENCY - 1;

            logic [NSTG-1:0]       r_v;
            logic [NSTG-1:0]       r_flt;
            logic [ADDR_WIDTH-1:0] r_pc   [NSTG];
            logic [INST_WIDTH-1:0] r_inst [NSTG];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_v   <= '0;
                    r_flt <= '0;
                    for (int i = 0; i < NSTG; i++) begin
                        r_pc[i] <= '0;
                    end
                end else begin
                    if (flush) begin
                        r_v <= '0;
                    end else begin
                        r_v[0] <= w_accept;
                        for (int i = 1; i < NSTG; i++) begin
                            r_v[i] <= r_v[i-1];
                        end
                    end
                    r_pc[0]  <= req_pc;
                    r_flt[0] <= w_req_fault;
                    for (int i = 1; i < NSTG; i++) begin
                        r_pc[i]  <= r_pc[i-1];
                        r_flt[i] <= r_flt[i-1];
                    end
                end
            end

            // Read-before-write: the read sees RAM contents prior to this edge's load.
            always_ff @(posedge clk) begin
                r_inst[0] <= r_mem[w_idx];
                for (int i = 1; i < NSTG; i++) begin
                    r_inst[i] <= r_inst[i-1];
                end
            end

            always_comb begin
                w_push       = r_v[NSTG-1];
                w_push_pc    = r_pc[NSTG-1];
                w_raw_inst   = r_inst[NSTG-1];
                w_push_fault = r_flt[NSTG-1];
            end
        end
    endgenerate

    assign w_push_inst = w_push_fault ? '0 : w_raw_inst;

`ifdef FETCH_MEM_ACCESS_FAULT_EN
    assign w_wdata = {w_push_pc, w_push_inst, w_push_fault};
    assign {resp_pc, resp_inst, resp_fault} = w_rdata;
`else
    assign w_wdata = {w_push_pc, w_push_inst};
    assign {resp_pc, resp_inst} = w_rdata;
`endif

    assign resp_valid = !w_empty;

    fetch_mem_resp_queue #(
        .WIDTH (EW),
        .DEPTH (RESP_DEPTH)
    ) u_resp_queue (
        .clk     (clk),
        .rst     (reset),
        .i_flush (flush),
        .i_push  (w_push),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_empty (w_empty),
        .o_rdata (w_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_mem_responder.sv
// ============================================================================
// Module   : tb_fetch_mem_responder
// Brief    : Directed self-checking bench for fetch_mem_responder (default
//            build; resp_fault is connected when FETCH_MEM_ACCESS_FAULT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fetch_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_pc;
    logic [31:0] resp_inst;
`ifdef FETCH_MEM_ACCESS_FAULT_EN
    logic        resp_fault;
`endif
    logic        flush;
    logic        load_we;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    int          checks = 0;
    int          errors = 0;
    int          acc;
    logic        rdy;
    logic [31:0] exp_mem [32];

    fetch_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_pc     (req_pc),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_pc    (resp_pc),
        .resp_inst  (resp_inst),
`ifdef FETCH_MEM_ACCESS_FAULT_EN
        .resp_fault (resp_fault),
`endif
        .flush      (flush),
        .load_we    (load_we),
        .load_addr  (load_addr),
        .load_data  (load_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_pc     = '0;
        resp_ready = 1'b0;
        flush      = 1'b0;
        load_we    = 1'b0;
        load_addr  = '0;
        load_data  = '0;

        for (int i = 0; i < 32; i++) begin
            exp_mem[i] = 32'h1000_0000 + 32'(i);
        end
        exp_mem[3]  = 32'h0050_0093;
        exp_mem[16] = 32'hABCD_0010;

        // Program load while held in reset
        for (int i = 0; i < 32; i++) begin
            load_we   = 1'b1;
            load_addr = 10'(i);
            load_data = exp_mem[i];
            tick();
        end
        load_we = 1'b0;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_pc", resp_pc, 32'd0);
        check("rst_resp_inst", resp_inst, 32'd0);

        tick();
        reset = 1'b0;
        #1;
        check("rel_req_ready", 32'(req_ready), 32'd1);

        // Single request, latency 2
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_pc     = 32'h0C;
        tick();
        req_valid = 1'b0;
        #1;
        check("single_n1_valid", 32'(resp_valid), 32'd0);
        tick();
        check("single_valid", 32'(resp_valid), 32'd1);
        check("single_pc", resp_pc, 32'h0C);
        check("single_inst", resp_inst, 32'h0050_0093);
        tick();
        check("single_drained", 32'(resp_valid), 32'd0);

        // Back-to-back stream
        for (int k = 0; k < 10; k++) begin
            if (k < 8) begin
                req_valid = 1'b1;
                req_pc    = 32'(4 * k);
            end else begin
                req_valid = 1'b0;
            end
            #1;
            if (k < 8) check("b2b_ready", 32'(req_ready), 32'd1);
            if (k >= 2) begin
                check("b2b_valid", 32'(resp_valid), 32'd1);
                check("b2b_pc", resp_pc, 32'(4 * (k - 2)));
                check("b2b_inst", resp_inst, exp_mem[k-2]);
            end
            tick();
        end
        check("b2b_drained", 32'(resp_valid), 32'd0);

        // Backpressure: credits cap outstanding requests at 4
        resp_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1;
            req_pc    = 32'h20 + 32'(4 * acc);
            #1;
            rdy = req_ready;
            tick();
            if (rdy) acc++;
        end
        req_valid = 1'b0;
        #1;
        check("bp_accepts", 32'(acc), 32'd4);
        check("bp_ready_low", 32'(req_ready), 32'd0);
        check("bp_head_pc", resp_pc, 32'h20);
        resp_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            check("bp_valid", 32'(resp_valid), 32'd1);
            check("bp_pc", resp_pc, 32'h20 + 32'(4 * p));
            check("bp_inst", resp_inst, exp_mem[8+p]);
            tick();
        end
        check("bp_resume", 32'(req_ready), 32'd1);
        check("bp_drained", 32'(resp_valid), 32'd0);

        // Flush with three requests in flight
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_pc    = 32'(4 * k);
            tick();
        end
        req_pc = 32'h30;
        flush  = 1'b1;
        #1;
        check("flush_ready_low", 32'(req_ready), 32'd0);
        tick();
        flush      = 1'b0;
        req_pc     = 32'h40;
        resp_ready = 1'b1;
        #1;
        check("flush_valid_cleared", 32'(resp_valid), 32'd0);
        check("flush_next_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        check("flush_no_stale", 32'(resp_valid), 32'd0);
        tick();
        check("flush_new_valid", 32'(resp_valid), 32'd1);
        check("flush_new_pc", resp_pc, 32'h40);
        check("flush_new_inst", resp_inst, 32'hABCD_0010);
        tick();
        check("flush_only_one", 32'(resp_valid), 32'd0);
        repeat (3) tick();
        check("flush_quiet", 32'(resp_valid), 32'd0);

        // Read-before-write on the same index
        load_we   = 1'b1;
        load_addr = 10'd5;
        load_data = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_pc    = 32'h14;
        tick();
        load_we   = 1'b0;
        req_valid = 1'b0;
        tick();
        check("rbw_pc", resp_pc, 32'h14);
        check("rbw_old_inst", resp_inst, exp_mem[5]);
        exp_mem[5] = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        check("rbw_new_valid", 32'(resp_valid), 32'd1);
        check("rbw_new_inst", resp_inst, exp_mem[5]);
        tick();

        // Asynchronous reset mid-traffic
        resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = 1'b1;
            req_pc    = 32'h50 + 32'(4 * k);
            tick();
        end
        req_valid = 1'b0;
        #1;
        check("ar_pre_valid", 32'(resp_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_valid_drop", 32'(resp_valid), 32'd0);
        check("ar_ready_drop", 32'(req_ready), 32'd0);
        check("ar_pc_zero", resp_pc, 32'd0);
        check("ar_inst_zero", resp_inst, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        check("ar_rel_ready", 32'(req_ready), 32'd1);
        check("ar_rel_valid", 32'(resp_valid), 32'd0);
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 1'b1;
            req_pc    = 32'h60 + 32'(4 * acc);
            #1;
            rdy = req_ready;
            tick();
            if (rdy) acc++;
        end
        req_valid = 1'b0;
        #1;
        check("ar_accepts", 32'(acc), 32'd4);
        resp_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            check("ar_resp_pc", resp_pc, 32'h60 + 32'(4 * p));
            check("ar_resp_inst", resp_inst, exp_mem[24+p]);
            tick();
        end
        check("ar_drained", 32'(resp_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
